// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcodes, FSM states, flag bundle.
// Latency: none (definitions only).
// Backpressure: none. MUL/DIV states exist only when ALU_MC_MULDIV_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_MUL   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_MULHU = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_DIVU  = 4'h7;
    localparam logic [3:0] OP_SLL   = 4'h8;
    localparam logic [3:0] OP_REMU  = 4'h9;
    localparam logic [3:0] OP_SRL   = 4'hA;
    localparam logic [3:0] OP_SRA   = 4'hB;
    localparam logic [3:0] OP_SLT   = 4'hC;
    localparam logic [3:0] OP_SLTU  = 4'hE;

`ifdef ALU_MC_MULDIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } flags_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned datapath: radix-2 shift-add multiply / restoring divide.
// Latency: WIDTH iterations after start; done is high during the last one.
// Backpressure: none; a new start restarts it, results hold until the next start.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] work;
    logic [2*WIDTH-1:0] work_nxt;
    logic [WIDTH-1:0]   b_q;
    logic               div_q;
    logic               busy;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;

    assign done = busy && (cnt == LAST);
    assign lo   = work[WIDTH-1:0];
    assign hi   = work[2*WIDTH-1:WIDTH];

    // One iteration step of either algorithm.
    always_comb begin
        add_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, b_q} : '0);
        trial    = work[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
        work_nxt = {add_sum, work[WIDTH-1:1]};
        if (div_q) begin
            if (trial[WIDTH]) begin
                work_nxt = {work[2*WIDTH-2:0], 1'b0};
            end else begin
                work_nxt = {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
            end
        end
    end

    // Operand capture on start, then one step per cycle until WIDTH steps are done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            work  <= {{WIDTH{1'b0}}, a};
            b_q   <= b;
            div_q <= is_div;
            busy  <= 1'b1;
            cnt   <= '0;
        end else if (busy) begin
            work <= work_nxt;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle ops plus optional iterative mul/div (ALU_MC_MULDIV_EN).
// Latency: 1 cycle for single-cycle ops, WIDTH+2 cycles for mul/mulhu/divu/remu.
// Backpressure: valid/ready; result and flags hold while out_valid && !out_ready.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out_flag,
    output logic             overflow,
    output logic             zero_flag
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    state_t           state;
    flags_t           flags_q;
    logic             accept;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             sub_v;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] sc_result;
    flags_t           sc_flags;

    assign in_ready       = (state == IDLE) && (!out_valid || out_ready);
    assign accept         = in_valid && in_ready;
    assign carry_out_flag = flags_q.carry;
    assign overflow       = flags_q.overflow;
    assign zero_flag      = flags_q.zero;

    // Single-cycle result and flags straight from the live inputs.
    always_comb begin
        add_full  = {1'b0, A} + {1'b0, B};
        sub_full  = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
        sub_v     = (A[MSB] != B[MSB]) && (sub_full[MSB] != A[MSB]);
        shamt     = B[SH_W-1:0];
        sc_result = '0;
        sc_flags  = '0;
        case (select)
            OP_ADD: begin
                sc_result         = add_full[WIDTH-1:0];
                sc_flags.carry    = add_full[WIDTH];
                sc_flags.overflow = (A[MSB] == B[MSB]) && (add_full[MSB] != A[MSB]);
            end
            OP_SUB: begin
                sc_result         = sub_full[WIDTH-1:0];
                sc_flags.carry    = sub_full[WIDTH];
                sc_flags.overflow = sub_v;
            end
            OP_AND: sc_result = A & B;
            OP_OR:  sc_result = A | B;
            OP_XOR: sc_result = A ^ B;
            OP_SLL: sc_result = A << shamt;
            OP_SRL: sc_result = A >> shamt;
            OP_SRA: sc_result = $signed(A) >>> shamt;
            // The comparator is the A-B subtractor: slt reports its signed
            // overflow, sltu reports its borrow.
            OP_SLT: begin
                sc_result         = {{(WIDTH-1){1'b0}}, sub_full[MSB] ^ sub_v};
                sc_flags.overflow = sub_v;
            end
            OP_SLTU: begin
                sc_result         = {{(WIDTH-1){1'b0}}, !sub_full[WIDTH]};
                sc_flags.overflow = !sub_full[WIDTH];
            end
`ifdef ALU_MC_MULDIV_EN
            // Only reached for B == 0; nonzero divisors go to the iterator.
            OP_DIVU: begin
                sc_result         = '1;
                sc_flags.overflow = 1'b1;
            end
            OP_REMU: begin
                sc_result         = A;
                sc_flags.overflow = 1'b1;
            end
`endif
            default: sc_result = '0;
        endcase
        sc_flags.zero = (sc_result == '0);
    end

`ifdef ALU_MC_MULDIV_EN
    logic             go_mul;
    logic             go_div;
    logic             iter_done;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] iter_res;
    flags_t           iter_flags;

    assign go_mul = is_mul_op(select);
    assign go_div = is_div_op(select) && (B != '0);

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && (go_mul || go_div)),
        .is_div (go_div),
        .a      (A),
        .b      (B),
        .done   (iter_done),
        .lo     (iter_lo),
        .hi     (iter_hi)
    );

    // Pick the half the captured opcode asked for and derive its flags.
    always_comb begin
        iter_res   = iter_lo;
        iter_flags = '0;
        case (op_q)
            OP_MUL: begin
                iter_res            = iter_lo;
                iter_flags.overflow = |iter_hi;
            end
            OP_MULHU: iter_res = iter_hi;
            OP_REMU:  iter_res = iter_hi;
            default:  iter_res = iter_lo;
        endcase
        iter_flags.zero = (iter_res == '0);
    end
`endif

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags_q   <= '0;
`ifdef ALU_MC_MULDIV_EN
            op_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef ALU_MC_MULDIV_EN
                        if (go_mul || go_div) begin
                            state     <= go_mul ? MUL : DIV;
                            op_q      <= select;
                            out_valid <= 1'b0;
                        end else begin
                            result    <= sc_result;
                            flags_q   <= sc_flags;
                            out_valid <= 1'b1;
                        end
`else
                        result    <= sc_result;
                        flags_q   <= sc_flags;
                        out_valid <= 1'b1;
`endif
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
`ifdef ALU_MC_MULDIV_EN
                MUL, DIV: begin
                    if (iter_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    result    <= iter_res;
                    flags_q   <= iter_flags;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
